// File: rtl/dose_pkg.sv
// Shared definitions for the pump dose controller: FSM encoding, channel
// bit positions and the default colour-component width.
package dose_pkg;

  localparam int DEFAULT_DW = 8;

  localparam int CH_R = 2;
  localparam int CH_G = 1;
  localparam int CH_B = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/dose_ctrl_if.sv
// Pump request/drive bundle between the sequencing FSM (master) and the
// dose controller (slave).
interface dose_ctrl_if
  import dose_pkg::*;
#(
  parameter int DW = DEFAULT_DW
);
  logic [2:0]    motor_en;
  logic [DW-1:0] r_val;
  logic [DW-1:0] g_val;
  logic [DW-1:0] b_val;
  logic [2:0]    motor_drv;
  logic [2:0]    flags;
  logic          busy;

  modport master (
    output motor_en, r_val, g_val, b_val,
    input  motor_drv, flags, busy
  );

  modport slave (
    input  motor_en, r_val, g_val, b_val,
    output motor_drv, flags, busy
  );
endinterface

// File: rtl/dose_ctrl_tick_gen.sv
// Dose-unit prescaler: counts 0..TICK_DIV-1 while not cleared and flags the
// last count of each unit.
module tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  output logic o_tick
);
  localparam int            PW   = $clog2(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clr || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + PW'(1);
    end
  end

  assign o_tick = !i_clr && (r_cnt == LAST);

endmodule

// File: rtl/dose_ctrl.sv
// Single-channel pump dose controller: latches a one-hot request, drives the
// pump for value*TICK_DIV cycles, then holds a completion flag until released.
module dose_ctrl
  import dose_pkg::*;
#(
  parameter int TICK_DIV = 50000,
  parameter int DW       = DEFAULT_DW
) (
  input  logic          clk,
  input  logic          reset,
  dose_ctrl_if.slave    bus
);
  state_t        r_state, w_state_nxt;
  logic [2:0]    r_chan, w_chan_nxt;
  logic [DW-1:0] r_count, w_count_nxt;
  logic [DW-1:0] w_load_val;
  logic          w_tick;
  logic          w_abort;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (r_state != ST_RUN),
    .o_tick (w_tick)
  );

  assign w_load_val = r_chan[CH_R] ? bus.r_val :
                      r_chan[CH_G] ? bus.g_val : bus.b_val;
  assign w_abort    = (bus.motor_en != r_chan);

  // NOTE: the reset branch clears every register asynchronously, so the
  // decoded pump drive drops the instant reset is asserted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_chan  <= 3'b000;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_chan  <= w_chan_nxt;
      r_count <= w_count_nxt;
    end
  end

  // NOTE: defaults first so no path through the case leaves a variable
  // unassigned and infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_chan_nxt  = r_chan;
    w_count_nxt = r_count;
    case (r_state)
      ST_IDLE: begin
        if ($onehot(bus.motor_en)) begin
          w_state_nxt = ST_LOAD;
          w_chan_nxt  = bus.motor_en;
        end
      end
      ST_LOAD: begin
        w_count_nxt = w_load_val;
        w_state_nxt = (w_load_val != '0) ? ST_RUN : ST_DONE;
      end
      ST_RUN: begin
        // Abort wins over a coincident tick; count never reaches zero here.
        if (w_abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_tick) begin
          w_count_nxt = r_count - DW'(1);
          if (r_count == DW'(1)) begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (w_abort) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign bus.motor_drv = (r_state == ST_RUN)  ? r_chan : 3'b000;
  assign bus.flags     = (r_state == ST_DONE) ? r_chan : 3'b000;
  assign bus.busy      = (r_state == ST_LOAD) || (r_state == ST_RUN);

endmodule

// File: tb/tb_dose_ctrl.sv
// Bench for dose_ctrl with TICK_DIV=4, DW=8: directed scenarios plus random
// doses compared against a cycle-offset model of the dose timeline.
module tb_dose_ctrl;
  localparam int T  = 4;
  localparam int DW = 8;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  dose_ctrl_if #(.DW(DW)) bus ();

  dose_ctrl #(.TICK_DIV(T), .DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Expected {busy, drive, flags} k cycles after a one-hot request is first
  // presented in IDLE; the request is withdrawn from cycle a onward.
  function automatic logic [6:0] model(input logic [2:0] ch, input int v,
                                       input int a, input int k);
    int         run_end;
    int         stop;
    logic       b;
    logic [2:0] d;
    logic [2:0] f;
    run_end = 2 + v * T;
    stop    = (a > 2) ? a : 2;
    b = 1'b0; d = 3'b000; f = 3'b000;
    if (k <= stop) begin
      b = (k >= 1) && (k < run_end);
      d = ((k >= 2) && (k < run_end)) ? ch : 3'b000;
      f = (k >= run_end) ? ch : 3'b000;
    end
    return {b, d, f};
  endfunction

  task automatic scramble_vals();
    bus.r_val = DW'($urandom);
    bus.g_val = DW'($urandom);
    bus.b_val = DW'($urandom);
  endtask

  // Starts at posedge+1 with the DUT idle; returns at posedge+1 of the first
  // cycle back in IDLE (with motor_en = leave_en).
  task automatic run_req(input string name, input logic [2:0] ch, input int v,
                         input int a, input logic [2:0] leave_en, input bit scramble);
    int         stop;
    logic [6:0] got;
    logic [6:0] exp;
    stop = (a > 2) ? a : 2;
    scramble_vals();
    if (ch[2]) bus.r_val = DW'(v);
    if (ch[1]) bus.g_val = DW'(v);
    if (ch[0]) bus.b_val = DW'(v);
    bus.motor_en = ch;
    for (int k = 0; k <= stop; k++) begin
      if (k == a) bus.motor_en = leave_en;
      if (scramble && k >= 2) scramble_vals();
      @(negedge clk);
      got = {bus.busy, bus.motor_drv, bus.flags};
      exp = model(ch, v, a, k);
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL %s cycle %0d: busy/drv/flags got %b required %b", name, k, got, exp);
      end
      total++;
      if ($countones(bus.motor_drv) > 1 || $countones(bus.flags) > 1 ||
          (bus.motor_drv != 3'b000 && bus.flags != 3'b000)) begin
        bad++;
        $display("FAIL %s_exclusive cycle %0d: drv=%b flags=%b", name, k, bus.motor_drv, bus.flags);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic idle_hold(input string name, input logic [2:0] en, input int n);
    logic [6:0] got;
    bus.motor_en = en;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      got = {bus.busy, bus.motor_drv, bus.flags};
      total++;
      if (got !== 7'b0) begin
        bad++;
        $display("FAIL %s cycle %0d: busy/drv/flags got %b required 0000000", name, k, got);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    bus.motor_en = 3'b100;
    scramble_vals();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (bus.motor_drv !== 3'b000) begin
      bad++; $display("FAIL reset_drv: got %b required 000", bus.motor_drv);
    end
    total++;
    if (bus.flags !== 3'b000) begin
      bad++; $display("FAIL reset_flags: got %b required 000", bus.flags);
    end
    total++;
    if (bus.busy !== 1'b0) begin
      bad++; $display("FAIL reset_busy: got %b required 0", bus.busy);
    end
    bus.motor_en = 3'b000;
    @(posedge clk); #1;
    reset = 1'b1;
    idle_hold("post_reset", 3'b000, 3);
  endtask

  task automatic test_single_red();
    run_req("red3", 3'b100, 3, 20, 3'b000, 1'b0);
    idle_hold("red3_release", 3'b000, 1);
  endtask

  task automatic test_sequence();
    run_req("seq_r", 3'b100, 2, 12, 3'b010, 1'b0);
    run_req("seq_y", 3'b010, 0, 4, 3'b001, 1'b0);
    run_req("seq_b", 3'b001, 1, 8, 3'b000, 1'b0);
    idle_hold("seq_end", 3'b000, 2);
  endtask

  task automatic test_illegal_request();
    idle_hold("multi_bit", 3'b110, 20);
    idle_hold("no_bit", 3'b000, 20);
  endtask

  task automatic test_abort();
    run_req("abort_g", 3'b010, 5, 7, 3'b000, 1'b0);
    idle_hold("abort_g_after", 3'b000, 3);
    run_req("load_ignore", 3'b001, 4, 1, 3'b000, 1'b0);
    run_req("abort_last", 3'b100, 2, 9, 3'b000, 1'b0);
    idle_hold("abort_last_after", 3'b000, 2);
  endtask

  task automatic test_max_value();
    run_req("max_b", 3'b001, 255, 2 + 255 * T + 3, 3'b000, 1'b1);
    idle_hold("max_b_release", 3'b000, 1);
  endtask

  task automatic test_reset_mid_run();
    bus.r_val    = 8'd3;
    bus.motor_en = 3'b100;
    repeat (5) begin
      @(posedge clk); #1;
    end
    total++;
    if (bus.motor_drv !== 3'b100) begin
      bad++; $display("FAIL rst_mid_pre: drv got %b required 100", bus.motor_drv);
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if ({bus.busy, bus.motor_drv, bus.flags} !== 7'b0) begin
      bad++;
      $display("FAIL rst_mid_async: busy/drv/flags got %b required 0000000",
               {bus.busy, bus.motor_drv, bus.flags});
    end
    @(posedge clk); #1;
    reset = 1'b1;
    run_req("rst_redo", 3'b100, 3, 16, 3'b000, 1'b0);
    idle_hold("rst_redo_release", 3'b000, 1);
  endtask

  task automatic test_random();
    logic [2:0] ch;
    logic [2:0] leave;
    int         v;
    int         a;
    for (int i = 0; i < 30; i++) begin
      ch = 3'b001 << $urandom_range(0, 2);
      v  = $urandom_range(0, 6);
      a  = $urandom_range(1, 2 + v * T + 3);
      do leave = 3'($urandom); while (leave == ch);
      run_req($sformatf("rand%0d", i), ch, v, a, leave, 1'b1);
    end
    idle_hold("rand_end", 3'b000, 2);
  endtask

  initial begin
    bus.motor_en = 3'b000;
    bus.r_val    = '0;
    bus.g_val    = '0;
    bus.b_val    = '0;
    test_reset();
    test_single_red();
    test_sequence();
    test_illegal_request();
    test_abort();
    test_max_value();
    test_reset_mid_run();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dose_ctrl.md
DOSE_CTRL -- requirements
Module: dose_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 50000, clk cycles per dose unit (1 ms at 50 MHz); legal range 2..65535.
REQ-002 Parameter DW, default 8, width of each colour component.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 motor_en  input  3  one-hot pump request from the sequencing FSM; bit2=R, bit1=Y(G), bit0=B.
REQ-006 r_val, g_val, b_val  input  DW each  latched colour components; dose length in units.
REQ-007 motor_drv  output  3  pump drive, one bit per channel, same bit order as motor_en.
REQ-008 flags  output  3  per-channel dose-complete level, same bit order; fed back to the FSM.
REQ-009 busy  output  1  high in LOAD or RUN.

Function
REQ-010 States IDLE, LOAD, RUN, DONE; all outputs registered or decoded from state plus the latched channel only.
REQ-011 IDLE: motor_drv=000, flags=000; exactly one motor_en bit set -> LOAD, latch that one-hot as chan; 000 or multi-bit -> stay IDLE.
REQ-012 LOAD (1 cycle): count <= component selected by chan (R->r_val, G->g_val, B->b_val), prescaler <= 0; next RUN if value !=0, else DONE.
REQ-013 RUN: motor_drv = chan; prescaler increments each cycle, wraps at TICK_DIV-1; tick = (prescaler == TICK_DIV-1).
REQ-014 RUN: on tick, count <= count-1; tick with count==1 -> DONE next cycle.
REQ-015 RUN duration exactly value*TICK_DIV cycles; motor_drv first high 2 cycles after motor_en first sampled one-hot.
REQ-016 DONE: motor_drv=000, flags=chan; held while motor_en==chan; motor_en!=chan -> IDLE next cycle (flags clear).
REQ-017 RUN abort: motor_en!=chan in any RUN cycle -> IDLE next cycle, motor_drv=000, no flag; abort takes priority over tick.
REQ-018 LOAD ignores motor_en; abort is checked from RUN onward.
REQ-019 r_val/g_val/b_val sampled only in LOAD; later changes do not affect an active dose.
REQ-020 Value 0 -> no drive; flags asserted 2 cycles after request.
REQ-021 Maximum value (2^DW-1): count never underflows; no wrap-around.
REQ-022 motor_drv and flags never have more than one bit set, and never both nonzero in the same cycle.

Reset
REQ-023 reset low: state=IDLE, chan=000, count=0, prescaler=0, motor_drv=000, flags=000, busy=0, immediately, independent of clk.
REQ-024 Reset asserted mid-RUN drops motor_drv the same instant; after release, a new dose starts only from a fresh one-hot request.

Structure
REQ-025 Shared package dose_pkg holds the state encoding, channel indices (R=2, G=1, B=0) and default DW.
REQ-026 Prescaler is sub-module tick_gen (clr input, TICK_DIV parameter, tick output); state/count logic stays in dose_ctrl.

Verification (TICK_DIV=4, DW=8)
REQ-027 r_val=3, motor_en=100 from cycle 0 -> LOAD cycle 1, motor_drv=100 cycles 2-13, flags=100 from cycle 14 until motor_en changes.
REQ-028 Full R->Y->B sequence, values 2/0/1 with FSM-style handshake -> drive 8 cycles R, flags=010 with no drive for Y, drive 4 cycles B, each flag clears 1 cycle after motor_en leaves that channel.
REQ-029 motor_en=110 or 000 held 20 cycles -> state stays IDLE, motor_drv=flags=000.
REQ-030 g_val=5, motor_en=010, motor_en set to 000 at cycle 7 -> motor_drv=000 from cycle 8, flags stay 000.
REQ-031 b_val=255 -> motor_drv=001 for exactly 1020 cycles, then flags=001; b_val changed mid-RUN has no effect.
REQ-032 reset pulsed low mid-RUN -> motor_drv=000 asynchronously; after release with motor_en held 100, a fresh dose of full length runs.
